// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed FIFO controller.
// Holds the output buffer depth and the level counter width function.
package sram_fifo_pkg;

    localparam int OUT_DEPTH = 2;

    // Level spans 0 .. DEPTH + OUT_DEPTH inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + OUT_DEPTH + 1);
    endfunction

endpackage

// File: rtl/sram_fifo_out_buf.sv
// Two-entry show-ahead buffer holding words returned by the SRAM.
// Ports: clk_i, arstn_i, wr_en/wr_data (capture), rd_en (pop), cnt, head.
module sram_fifo_out_buf
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [1:0]       cnt,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] tail;
    logic             rd;
    logic [1:0]       cnt_left;

    assign rd       = rd_en & (cnt != 2'd0);
    // Entries remaining after this cycle's pop; a write lands there.
    assign cnt_left = cnt - {1'b0, rd};

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            cnt <= cnt_left + {1'b0, wr_en};
            if (rd && cnt == 2'd2) begin
                head <= tail;
            end
            if (wr_en) begin
                if (cnt_left == 2'd0) begin
                    head <= wr_data;
                end else begin
                    tail <= wr_data;
                end
            end
        end
    end

    no_overflow: assert property (
        @(posedge clk_i) disable iff (!arstn_i)
        !(wr_en && !rd && cnt == 2'(OUT_DEPTH))
    );

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller sequencing a dual-port SRAM with 1-cycle read latency.
// Ports: s_* push side, m_* show-ahead pop side, sram_* memory ports.
// Optional SRAM_FIFO_CTRL_LEVEL_EN adds level_o and almost_full_o.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              s_valid_i,
    input  logic [WIDTH-1:0]  s_data_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    output logic [WIDTH-1:0]  m_data_o,
    input  logic              m_ready_i,
    output logic              sram_wen_o,
    output logic [ADDR_W-1:0] sram_waddr_o,
    output logic [WIDTH-1:0]  sram_wdata_o,
    output logic              sram_ren_o,
    output logic [ADDR_W-1:0] sram_raddr_o,
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic              almost_full_o,
`endif
    input  logic [WIDTH-1:0]  sram_rdata_i
);

    localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   sram_cnt;
    logic [ADDR_W:0]   sram_cnt_nxt;
    logic              inflight;
    logic              running;
    logic [1:0]        out_cnt;
    logic [2:0]        occ;
    logic              push;
    logic              pop;
    logic              ren;

    // running keeps s_ready_o low until the first edge after reset.
    assign s_ready_o = running & (sram_cnt != FULL);
    assign push      = s_valid_i & s_ready_o;
    assign m_valid_o = (out_cnt != 2'd0);
    assign pop       = m_valid_o & m_ready_i;

    // Buffer occupancy after this edge; a read is issued only if its
    // data will still find a free slot when it returns.
    assign occ = 3'(out_cnt) + 3'(inflight) - 3'(pop);
    assign ren = (sram_cnt != '0) && (occ <= 3'(OUT_DEPTH - 1));

    assign sram_cnt_nxt = sram_cnt + (ADDR_W+1)'(push)
                        - (ADDR_W+1)'(ren);

    assign sram_wen_o   = push;
    assign sram_waddr_o = wr_ptr;
    assign sram_wdata_o = s_data_i;
    assign sram_ren_o   = ren;
    assign sram_raddr_o = rd_ptr;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            running  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            running  <= 1'b1;
            sram_cnt <= sram_cnt_nxt;
            inflight <= ren;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
            end
            if (ren) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + ADDR_W'(1);
            end
        end
    end

    sram_fifo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .wr_en   (inflight),
        .wr_data (sram_rdata_i),
        .rd_en   (pop),
        .cnt     (out_cnt),
        .head    (m_data_o)
    );

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    localparam int LVL_W = level_width(DEPTH);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            level_o <= '0;
        end else begin
            level_o <= LVL_W'(sram_cnt_nxt) + LVL_W'(ren) + LVL_W'(occ);
        end
    end

    assign almost_full_o = (sram_cnt >= (ADDR_W+1)'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural SRAM and
// a queue-based reference model of FIFO order and visibility timing.
module tb_sram_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             arstn;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             sram_wen;
    logic [AW-1:0]    sram_waddr;
    logic [WIDTH-1:0] sram_wdata;
    logic             sram_ren;
    logic [AW-1:0]    sram_raddr;
    logic [WIDTH-1:0] sram_rdata;
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    logic [$clog2(DEPTH+3)-1:0] level;
    logic             almost_full;
`endif

    sram_fifo_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .s_valid_i    (s_valid),
        .s_data_i     (s_data),
        .s_ready_o    (s_ready),
        .m_valid_o    (m_valid),
        .m_data_o     (m_data),
        .m_ready_i    (m_ready),
        .sram_wen_o   (sram_wen),
        .sram_waddr_o (sram_waddr),
        .sram_wdata_o (sram_wdata),
        .sram_ren_o   (sram_ren),
        .sram_raddr_o (sram_raddr),
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
        .level_o       (level),
        .almost_full_o (almost_full),
`endif
        .sram_rdata_i (sram_rdata)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_wen === 1'b1) mem[sram_waddr] <= sram_wdata;
        if (sram_ren === 1'b1) sram_rdata <= mem[sram_raddr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [WIDTH-1:0] q [$];
    int qt [$];
    int wa = 0;
    int ra = 0;
    int pushed = 0;
    int reads = 0;
    int pops = 0;
    bit stall_prev = 0;
    logic [WIDTH-1:0] stall_data;

    task automatic model_clear();
        q.delete();
        qt.delete();
        wa = 0;
        ra = 0;
        pushed = 0;
        reads = 0;
        stall_prev = 0;
    endtask

    // Sample at the falling edge and update the reference model.
    task automatic half1();
        bit exp_mv;
        bit p;
        bit pp;
        @(negedge clk);
        if (stall_prev) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== stall_data) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h want 1 %h",
                         m_valid, m_data, stall_data);
            end
        end
        exp_mv = (q.size() > 0) && (cyc - qt[0] >= 3);
        checks++;
        if (m_valid !== exp_mv) begin
            errors++;
            $display("FAIL m_valid: cyc=%0d got %b want %b",
                     cyc, m_valid, exp_mv);
        end
        if (exp_mv) begin
            checks++;
            if (m_data !== q[0]) begin
                errors++;
                $display("FAIL m_data: got %h want %h", m_data, q[0]);
            end
        end
        if (q.size() < DEPTH) begin
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL s_ready_low: stored=%0d got %b",
                         q.size(), s_ready);
            end
        end
        if (q.size() >= DEPTH + 2) begin
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL s_ready_full: got %b want 0", s_ready);
            end
        end
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
        checks++;
        if (level !== q.size()) begin
            errors++;
            $display("FAIL level: got %0d want %0d", level, q.size());
        end
`endif
        p  = (s_valid === 1'b1) && (s_ready === 1'b1);
        pp = (m_valid === 1'b1) && (m_ready === 1'b1);
        checks++;
        if (p) begin
            if (sram_wen !== 1'b1 || sram_waddr !== AW'(wa)
                || sram_wdata !== s_data) begin
                errors++;
                $display("FAIL sram_write: wen=%b addr=%0d data=%h want 1 %0d %h",
                         sram_wen, sram_waddr, sram_wdata, wa, s_data);
            end
            wa = (wa + 1) % DEPTH;
        end else if (sram_wen !== 1'b0) begin
            errors++;
            $display("FAIL sram_wen_idle: got %b want 0", sram_wen);
        end
        if (sram_ren === 1'b1) begin
            checks++;
            if (sram_raddr !== AW'(ra) || reads >= pushed) begin
                errors++;
                $display("FAIL sram_read: addr=%0d want %0d reads=%0d pushed=%0d",
                         sram_raddr, ra, reads, pushed);
            end
            ra = (ra + 1) % DEPTH;
            reads++;
        end
        if (pp && q.size() > 0) begin
            void'(q.pop_front());
            void'(qt.pop_front());
            pops++;
        end
        if (p) begin
            q.push_back(s_data);
            qt.push_back(cyc);
            pushed++;
        end
        stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
        stall_data = m_data;
    endtask

    task automatic half2();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        half1();
        half2();
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        #3;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_out: v=%b r=%b d=%h want 0 0 00",
                     m_valid, s_ready, m_data);
        end
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: r=%b v=%b want 1 0",
                     s_ready, m_valid);
        end
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 8'hA5;
        half1();
        checks++;
        if (sram_wen !== 1'b1 || sram_waddr !== '0) begin
            errors++;
            $display("FAIL single_wen: wen=%b addr=%0d want 1 0",
                     sram_wen, sram_waddr);
        end
        half2();
        s_valid = 1'b0;
        half1();
        checks++;
        if (sram_ren !== 1'b1 || sram_raddr !== '0) begin
            errors++;
            $display("FAIL single_ren: ren=%b addr=%0d want 1 0",
                     sram_ren, sram_raddr);
        end
        half2();
        tick();
        half1();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_out: v=%b d=%h want 1 a5", m_valid, m_data);
        end
        half2();
        half1();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: v=%b want 0", m_valid);
        end
        half2();
    endtask

    task automatic test_fill();
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            s_valid = 1'b1;
            s_data = WIDTH'(i);
            half1();
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready: word %0d got %b want 1", i, s_ready);
            end
            half2();
        end
        s_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            half1();
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL fill_full: got %b want 0", s_ready);
            end
            half2();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            half1();
            checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(i)) begin
                errors++;
                $display("FAIL fill_drain: v=%b d=%h want 1 %h",
                         m_valid, m_data, WIDTH'(i));
            end
            half2();
        end
        half1();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty: v=%b want 0", m_valid);
        end
        half2();
    endtask

    task automatic test_back_to_back();
        int p0;
        m_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 100; k++) begin
            s_valid = 1'b1;
            s_data = WIDTH'(k);
            tick();
        end
        checks++;
        if (pops - p0 !== 97) begin
            errors++;
            $display("FAIL stream_rate: pops=%0d want 97", pops - p0);
        end
        s_valid = 1'b0;
        repeat (6) tick();
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL stream_drain: left=%0d want 0", q.size());
        end
    endtask

    task automatic test_random();
        int target;
        int budget;
        target = pushed + 2000;
        budget = 0;
        while (pushed < target && budget < 30000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = WIDTH'($urandom);
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
            budget++;
        end
        checks++;
        if (pushed < target) begin
            errors++;
            $display("FAIL random_budget: pushed=%0d want %0d", pushed, target);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 50) begin
            tick();
            budget++;
        end
        tick();
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL random_drain: left=%0d want 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = 8'h40 + WIDTH'(i);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        arstn = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL midreset_out: v=%b r=%b d=%h want 0 0 00",
                     m_valid, s_ready, m_data);
        end
        @(posedge clk);
        #1;
        arstn = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: r=%b v=%b want 1 0",
                     s_ready, m_valid);
        end
        m_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = 8'h80 + WIDTH'(i);
            tick();
        end
        s_valid = 1'b0;
        repeat (6) tick();
        checks++;
        if (pops - p0 !== 4 || q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_new: pops=%0d left=%0d want 4 0",
                     pops - p0, q.size());
        end
    endtask

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    task automatic test_level();
        m_ready = 1'b0;
        half1();
        checks++;
        if (almost_full !== 1'b0) begin
            errors++;
            $display("FAIL level_af_start: got %b want 0", almost_full);
        end
        half2();
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1;
            s_data = WIDTH'(i);
            tick();
        end
        s_valid = 1'b0;
        half1();
        checks++;
        if (level !== 9 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL level_nine: level=%0d af=%b want 9 1",
                     level, almost_full);
        end
        half2();
        m_ready = 1'b1;
        repeat (12) tick();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
        test_level();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
